// File: rtl/cla_seq_adder.sv
// Multi-cycle add/subtract sequencer: round-robin between two requesters, one
// byte per cycle through an external 8-bit carry-lookahead slice, LSB first.
module cla_seq_adder #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [8*NBYTES-1:0]   req0_a,
    input  logic [8*NBYTES-1:0]   req0_b,
    input  logic                  req0_sub,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [8*NBYTES-1:0]   req1_a,
    input  logic [8*NBYTES-1:0]   req1_b,
    input  logic                  req1_sub,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [8*NBYTES-1:0]   resp_sum,
    output logic                  resp_cout,
    output logic                  resp_ovf,
    output logic                  resp_id,
    output logic [7:0]            slice_a,
    output logic [7:0]            slice_b,
    output logic                  slice_cin,
    input  logic [7:0]            slice_sum,
    input  logic                  slice_g,
    input  logic                  slice_p
);

    localparam int W  = 8 * NBYTES;
    localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Carry into the next byte from the slice's group generate/propagate.
    function automatic logic chain_carry(input logic g, input logic p, input logic c);
        return g | (p & c);
    endfunction

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) & (s_msb != a_msb);
    endfunction

    state_t          state_r, state_s;
    logic [W-1:0]    a_r, b_r, sum_r;
    logic [KW-1:0]   k_r;
    logic            carry_r, last_r, id_r, cout_r, ovf_r, valid_r;
    logic            grant_s, gvalid_s, accept_s, resp_hs_s, carry_s, ovf_s;
    logic [KW+2:0]   bit_idx_s;

    // Round-robin grant; on a tie the requester not served last wins.
    always_comb begin
        gvalid_s = 1'b0;
        grant_s  = 1'b0;
        if (req0_valid && req1_valid) begin
            gvalid_s = 1'b1;
            grant_s  = ~last_r;
        end else if (req0_valid) begin
            gvalid_s = 1'b1;
            grant_s  = 1'b0;
        end else if (req1_valid) begin
            gvalid_s = 1'b1;
            grant_s  = 1'b1;
        end else begin
            gvalid_s = 1'b0;
            grant_s  = 1'b0;
        end
    end

    assign req0_ready = rst_n & (state_r == IDLE) & gvalid_s & ~grant_s;
    assign req1_ready = rst_n & (state_r == IDLE) & gvalid_s &  grant_s;
    assign accept_s   = req0_ready | req1_ready;
    assign resp_hs_s  = valid_r & resp_ready;
    assign bit_idx_s  = {k_r, 3'b000};
    assign carry_s    = chain_carry(slice_g, slice_p, carry_r);
    assign ovf_s      = signed_ovf(a_r[W-1], b_r[W-1], slice_sum[7]);

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = RUN;
                else          state_s = IDLE;
            end
            RUN: begin
                if (k_r == K_LAST) state_s = DONE;
                else               state_s = RUN;
            end
            DONE: begin
                if (resp_hs_s) state_s = IDLE;
                else           state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_s;
    end

    // Slice drive: current byte in RUN, quiet otherwise.
    always_comb begin
        slice_a   = 8'h00;
        slice_b   = 8'h00;
        slice_cin = 1'b0;
        if (rst_n && (state_r == RUN)) begin
            slice_a   = a_r[bit_idx_s +: 8];
            slice_b   = b_r[bit_idx_s +: 8];
            slice_cin = carry_r;
        end else begin
            slice_a   = 8'h00;
            slice_b   = 8'h00;
            slice_cin = 1'b0;
        end
    end

    // Operand capture, byte sequencing and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            k_r     <= '0;
            carry_r <= 1'b0;
            last_r  <= 1'b1;
            id_r    <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        // Subtraction is A + ~B + 1: invert B, seed carry with 1.
                        a_r     <= grant_s ? req1_a : req0_a;
                        b_r     <= grant_s ? (req1_sub ? ~req1_b : req1_b)
                                           : (req0_sub ? ~req0_b : req0_b);
                        carry_r <= grant_s ? req1_sub : req0_sub;
                        id_r    <= grant_s;
                        last_r  <= grant_s;
                        k_r     <= '0;
                    end
                end
                RUN: begin
                    sum_r[bit_idx_s +: 8] <= slice_sum;
                    carry_r               <= carry_s;
                    if (k_r == K_LAST) begin
                        valid_r <= 1'b1;
                        cout_r  <= carry_s;
                        ovf_r   <= ovf_s;
                    end else begin
                        k_r <= k_r + 1'b1;
                    end
                end
                DONE: begin
                    if (resp_hs_s) valid_r <= 1'b0;
                end
                default: begin
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign resp_valid = valid_r;
    assign resp_sum   = sum_r;
    assign resp_cout  = cout_r;
    assign resp_ovf   = ovf_r;
    assign resp_id    = id_r;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder with a behavioural 8-bit CLA slice model.
module tb_cla_seq_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_sub;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_sub;
    logic [31:0] req1_a, req1_b;
    logic        resp_valid, resp_ready, resp_cout, resp_ovf, resp_id;
    logic [31:0] resp_sum;
    logic [7:0]  slice_a, slice_b, slice_sum;
    logic        slice_cin, slice_g, slice_p;
    logic [8:0]  ab_sum, abc_sum;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    cla_seq_adder #(.NBYTES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_sub(req1_sub),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_sum(resp_sum),
        .resp_cout(resp_cout), .resp_ovf(resp_ovf), .resp_id(resp_id),
        .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
        .slice_sum(slice_sum), .slice_g(slice_g), .slice_p(slice_p)
    );

    // Reference CLA slice.
    assign ab_sum    = {1'b0, slice_a} + {1'b0, slice_b};
    assign abc_sum   = ab_sum + {8'h00, slice_cin};
    assign slice_sum = abc_sum[7:0];
    assign slice_g   = ab_sum[8];
    assign slice_p   = &(slice_a ^ slice_b);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input logic id, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if ((id ? req1_ready : req0_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_resp(output int n, output logic [3:0] cins);
        n = 0;
        cins = 4'h0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i <= 4) cins[i-1] = slice_cin;
            if (resp_valid === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n == 0) check("resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input vec_t v, input bit chk_cin);
        bit         ok;
        int         lat;
        logic [3:0] cins;
        @(posedge clk); #1;
        resp_ready = 1'b1;
        if (v.id) begin
            req1_a = v.a; req1_b = v.b; req1_sub = v.sub; req1_valid = 1'b1;
        end else begin
            req0_a = v.a; req0_b = v.b; req0_sub = v.sub; req0_valid = 1'b1;
        end
        wait_ready(v.id, ok);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (ok) begin
            wait_resp(lat, cins);
            check("latency", lat, 32'd5);
            check("sum", resp_sum, v.sum);
            check("cout", {31'd0, resp_cout}, {31'd0, v.cout});
            check("ovf", {31'd0, resp_ovf}, {31'd0, v.ovf});
            check("id", {31'd0, resp_id}, {31'd0, v.id});
            if (chk_cin) check("cin_seq", {28'd0, cins}, 32'h0000000e);
            @(posedge clk);
        end
    endtask

    initial begin
        int         n;
        int         prev;
        bit         ok;
        logic [3:0] cins;

        vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 32'h00000007, 32'h00000007, 1'b1, 32'h00000000, 1'b1, 1'b0};

        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd0; req0_b = 32'd0; req0_sub = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd0; req1_b = 32'd0; req1_sub = 1'b0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_sum", resp_sum, 32'd0);
        check("rst_resp_flags", {29'd0, resp_cout, resp_ovf, resp_id}, 32'd0);
        check("rst_slice", {15'd0, slice_a, slice_b, slice_cin}, 32'd0);
        check("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Round-robin with both requesters continuously valid.
        req0_a = 32'd1;  req0_b = 32'd2;  req0_sub = 1'b0;
        req1_a = 32'd10; req1_b = 32'd20; req1_sub = 1'b0;
        resp_ready = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_resp(n, cins);
            check("rr_id", {31'd0, resp_id}, i[31:0] & 32'd1);
            check("rr_sum", resp_sum, (i % 2 == 0) ? 32'd3 : 32'd30);
            if (i > 0) check("rr_spacing", cyc - prev, 32'd6);
            prev = cyc;
            if (i == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            @(posedge clk);
        end

        // Directed vector table; the first entry also checks the carry ripple.
        for (int i = 0; i < 7; i++) run_op(vecs[i], i == 0);

        // Backpressure: response held, requests ignored while busy.
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req0_a = 32'd3; req0_b = 32'd4; req0_sub = 1'b0; req0_valid = 1'b1;
        wait_ready(1'b0, ok);
        @(posedge clk); #1;
        req1_a = 32'd100; req1_b = 32'd1; req1_sub = 1'b0; req1_valid = 1'b1;
        wait_resp(n, cins);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, resp_valid}, 32'd1);
            check("bp_sum", resp_sum, 32'd7);
            check("bp_flags", {29'd0, resp_cout, resp_ovf, resp_id}, 32'd0);
            check("bp_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_valid", {31'd0, resp_valid}, 32'd0);
        check("bp_next_grant", {30'd0, req0_ready, req1_ready}, 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_resp(n, cins);
        check("bp_next_sum", resp_sum, 32'd101);
        check("bp_next_id", {31'd0, resp_id}, 32'd1);
        @(posedge clk);

        // Reset in the middle of RUN.
        @(posedge clk); #1;
        req0_a = 32'hAAAA0000; req0_b = 32'h00005555; req0_sub = 1'b0; req0_valid = 1'b1;
        wait_ready(1'b0, ok);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        req0_a = 32'h12345678; req0_b = 32'h11111111; req0_sub = 1'b0; req0_valid = 1'b1;
        req1_a = 32'h00000001; req1_b = 32'h00000001; req1_sub = 1'b0; req1_valid = 1'b1;
        @(negedge clk);
        check("rstmid_ready_low", {30'd0, req0_ready, req1_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_no_resp", {31'd0, resp_valid}, 32'd0);
        check("rstmid_tie_req0", {30'd0, req0_ready, req1_ready}, 32'd2);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_resp(n, cins);
        check("rstmid_latency", n, 32'd5);
        check("rstmid_sum", resp_sum, 32'h23456789);
        check("rstmid_id", {31'd0, resp_id}, 32'd0);
        @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
